// File: rtl/pc_call_stack_pkg.sv
// rtl/pc_call_stack_pkg.sv - op codes shared by the PC unit and its bench
package pc_call_stack_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 3'd0,
    OP_INC     = 3'd1,
    OP_LOAD_LO = 3'd2,
    OP_LOAD_HI = 3'd3,
    OP_JUMP    = 3'd4,
    OP_BRANCH  = 3'd5,
    OP_CALL    = 3'd6,
    OP_RET     = 3'd7
  } op_e;

endpackage

// File: rtl/pc_call_stack_addr_stack.sv
// rtl/pc_call_stack_addr_stack.sv - parameterised LIFO of return addresses
module addr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IW-1:0]    wr_idx, top_idx;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign wr_idx  = IW'(count_q);
  assign top_idx = IW'(count_q - CW'(1));
  assign dout    = mem_q[top_idx];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      count_d       = count_q + CW'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  // Entry contents are don't-care after reset; only the count is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with jump target latch, relative
// branches and a return-address stack with sticky overflow/underflow fault
module pc_call_stack
  import pc_call_stack_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_fault,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  fault
);

  if (ADDR_WIDTH != 2 * DATA_WIDTH) begin : g_bad_width
    $error("pc_call_stack: ADDR_WIDTH must equal 2*DATA_WIDTH");
  end
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("pc_call_stack: STACK_DEPTH must be at least 1");
  end

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, target_q, target_d;
  logic                  fault_q, fault_d;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] stk_dout;
  logic [$clog2(STACK_DEPTH+1)-1:0] stk_count;
  logic                  stk_empty, stk_full;

  addr_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q),
    .dout  (stk_dout),
    .count (stk_count),
    .empty (stk_empty),
    .full  (stk_full)
  );

  always_comb begin
    pc_d     = pc_q;
    target_d = target_q;
    fault_d  = fault_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (clear_fault) fault_d = 1'b0;
    // A fault raised on this edge overrides a simultaneous clear.
    if (en) begin
      case (op_e'(op))
        OP_INC:     pc_d = pc_q + ADDR_WIDTH'(1);
        OP_LOAD_LO: target_d[DATA_WIDTH-1:0] = data_in;
        OP_LOAD_HI: target_d[ADDR_WIDTH-1:DATA_WIDTH] = data_in;
        OP_JUMP:    pc_d = target_q;
        OP_BRANCH:  pc_d = pc_q + {{(ADDR_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
        OP_CALL: begin
          if (stk_full) fault_d = 1'b1;
          else begin
            push = 1'b1;
            pc_d = target_q;
          end
        end
        OP_RET: begin
          if (stk_empty) fault_d = 1'b1;
          else begin
            pop  = 1'b1;
            pc_d = stk_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      target_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      target_q <= target_d;
      fault_q  <= fault_d;
    end
  end

  assign pc          = pc_q;
  assign target      = target_q;
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb/tb_pc_call_stack.sv - directed bench with a queue-based reference model
module tb_pc_call_stack;
  import pc_call_stack_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  data_in = 8'd0;
  logic        clear_fault = 1'b0;
  logic [15:0] pc, target;
  logic        stack_empty, stack_full, fault;

  pc_call_stack #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .data_in     (data_in),
    .clear_fault (clear_fault),
    .pc          (pc),
    .target      (target),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  logic [15:0] pc_m = 16'd0, tgt_m = 16'd0;
  logic        fault_m = 1'b0;
  logic [15:0] stk_m [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("pc", 32'(pc), 32'(pc_m));
      check("target", 32'(target), 32'(tgt_m));
      check("stack_empty", 32'(stack_empty), 32'(stk_m.size() == 0));
      check("stack_full", 32'(stack_full), 32'(stk_m.size() == DEPTH));
      check("fault", 32'(fault), 32'(fault_m));
    end
  end

  task automatic model_reset();
    pc_m = 16'd0;
    tgt_m = 16'd0;
    fault_m = 1'b0;
    stk_m.delete();
  endtask

  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] d, input logic c);
    logic [15:0] npc, ntg;
    logic        nf;
    bit          do_push, do_pop;
    en = e; op = o; data_in = d; clear_fault = c;
    npc = pc_m; ntg = tgt_m; nf = fault_m; do_push = 0; do_pop = 0;
    if (c) nf = 1'b0;
    if (e) begin
      case (o)
        3'd1: npc = 16'(pc_m + 16'd1);
        3'd2: ntg = {tgt_m[15:8], d};
        3'd3: ntg = {d, tgt_m[7:0]};
        3'd4: npc = tgt_m;
        3'd5: npc = 16'(int'(pc_m) + int'($signed(d)));
        3'd6: if (stk_m.size() == DEPTH) nf = 1'b1; else begin do_push = 1; npc = tgt_m; end
        3'd7: if (stk_m.size() == 0) nf = 1'b1; else begin do_pop = 1; npc = stk_m[$]; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (do_push) stk_m.push_back(pc_m);
    if (do_pop) void'(stk_m.pop_back());
    pc_m = npc; tgt_m = ntg; fault_m = nf;
    en = 1'b0; op = 3'd0; data_in = 8'd0; clear_fault = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [7:0] d = 8'd0);
    step(1'b1, o, d, 1'b0);
  endtask

  task automatic set_target(input logic [15:0] t);
    run(OP_LOAD_LO, t[7:0]);
    run(OP_LOAD_HI, t[15:8]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);
    check("rst_full", 32'(stack_full), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    chk_on = 1'b1;

    repeat (3) run(OP_INC);
    check("inc3", 32'(pc), 32'h0003);

    // Push something, then reset asynchronously mid-cycle.
    run(OP_CALL);
    en = 1'b1; op = OP_INC;
    #3 reset = 1'b0;
    model_reset();
    #1;
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_empty", 32'(stack_empty), 32'h1);
    check("arst_fault", 32'(fault), 32'h0);
    en = 1'b0; op = 3'd0;
    @(posedge clk);
    #1 reset = 1'b1;

    set_target(16'h1234);
    run(OP_JUMP);
    check("jump_tgt", 32'(target), 32'h1234);
    check("jump_pc", 32'(pc), 32'h1234);

    set_target(16'hFFFF);
    run(OP_JUMP);
    run(OP_INC);
    check("inc_wrap", 32'(pc), 32'h0000);

    set_target(16'h0010);
    run(OP_JUMP);
    run(OP_BRANCH, 8'hF0);
    check("br_back", 32'(pc), 32'h0000);
    run(OP_BRANCH, 8'hFF);
    check("br_under", 32'(pc), 32'hFFFF);
    run(OP_BRANCH, 8'h7F);
    check("br_fwd_wrap", 32'(pc), 32'h007E);

    step(1'b0, OP_INC, 8'h00, 1'b0);
    check("en_off", 32'(pc), 32'h007E);

    set_target(16'h0005);
    run(OP_JUMP);
    set_target(16'h0100);
    run(OP_CALL);
    check("call1", 32'(pc), 32'h0100);
    run(OP_INC);
    check("call1_inc", 32'(pc), 32'h0101);
    set_target(16'h0200);
    run(OP_CALL);
    check("call2", 32'(pc), 32'h0200);
    set_target(16'h0300);
    run(OP_CALL);
    check("call3", 32'(pc), 32'h0300);
    set_target(16'h0400);
    run(OP_CALL);
    check("call4", 32'(pc), 32'h0400);
    check("call4_full", 32'(stack_full), 32'h1);
    run(OP_CALL);
    check("ovf_fault", 32'(fault), 32'h1);
    check("ovf_pc", 32'(pc), 32'h0400);
    check("tgt_kept", 32'(target), 32'h0400);
    step(1'b0, OP_NOP, 8'h00, 1'b1);
    check("clr_fault", 32'(fault), 32'h0);

    run(OP_RET);
    check("ret1", 32'(pc), 32'h0300);
    run(OP_RET);
    check("ret2", 32'(pc), 32'h0200);
    run(OP_RET);
    check("ret3", 32'(pc), 32'h0101);
    run(OP_RET);
    check("ret4", 32'(pc), 32'h0005);
    check("ret4_empty", 32'(stack_empty), 32'h1);
    run(OP_RET);
    check("unf_fault", 32'(fault), 32'h1);
    check("unf_pc", 32'(pc), 32'h0005);
    step(1'b1, OP_NOP, 8'h00, 1'b1);
    check("clr_fault2", 32'(fault), 32'h0);
    step(1'b1, OP_RET, 8'h00, 1'b1);
    check("set_wins", 32'(fault), 32'h1);
    step(1'b0, OP_NOP, 8'h00, 1'b1);

    set_target(16'hBEEF);
    run(OP_CALL);
    run(OP_RET);
    check("call_ret", 32'(pc), 32'h0005);

    @(posedge clk);
    #1 chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
